// File: rtl/fwd_bypass_unit_pkg.sv
// Shared definitions for the operand-forwarding unit.
//
// Contents:
//   fwd_sel_e      fixed select codes for the live pipeline producers
//   SEL_HIST_BASE  history entry k (1 = youngest) reports SEL_HIST_BASE + k
//   REG_ZERO       architectural zero register, never forwarded
//   hist_entry_t   one retired-writeback record at the default widths
//                  (the top keeps the same fields in flat vectors so that
//                  DATA_W / REG_AW stay overridable)
package fwd_bypass_unit_pkg;

    typedef enum logic [1:0] {
        SEL_RF  = 2'd0,
        SEL_EX  = 2'd1,
        SEL_MEM = 2'd2,
        SEL_WB  = 2'd3
    } fwd_sel_e;

    localparam int SEL_HIST_BASE = 3;
    localparam int REG_ZERO      = 0;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } hist_entry_t;

endpackage

// File: rtl/fwd_lookup.sv
// Priority match for a single source operand.
//
// Ports:
//   rs / rf_data                 operand register address and RF read data
//   ex_* / mem_* / wb_*          live producers (EX youngest)
//   hist_valid/hist_rd/hist_data retired writebacks, entry index 0 = youngest
//   data / sel                   winning value and its source code
//   load_use                     winner is EX but its result is not ready yet
module fwd_lookup
    import fwd_bypass_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2,
    parameter int SEL_W  = 3
) (
    input  logic [REG_AW-1:0]       rs,
    input  logic [DATA_W-1:0]       rf_data,
    input  logic                    ex_we,
    input  logic [REG_AW-1:0]       ex_rd,
    input  logic [DATA_W-1:0]       ex_data,
    input  logic                    ex_ready,
    input  logic                    mem_we,
    input  logic [REG_AW-1:0]       mem_rd,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic                    wb_we,
    input  logic [REG_AW-1:0]       wb_rd,
    input  logic [DATA_W-1:0]       wb_data,
    input  logic [DEPTH-1:0]        hist_valid,
    input  logic [DEPTH*REG_AW-1:0] hist_rd,
    input  logic [DEPTH*DATA_W-1:0] hist_data,
    output logic [DATA_W-1:0]       data,
    output logic [SEL_W-1:0]        sel,
    output logic                    load_use
);

    logic rs_live;

    assign rs_live = (rs != REG_AW'(REG_ZERO));

    // Candidates are visited oldest to youngest so that each later match
    // overrides an earlier one; the last assignment standing is the youngest.
    always_comb begin
        data = rf_data;
        sel  = SEL_W'(SEL_RF);
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rs_live && hist_valid[k] && (hist_rd[k*REG_AW +: REG_AW] == rs)) begin
                data = hist_data[k*DATA_W +: DATA_W];
                sel  = SEL_W'(SEL_HIST_BASE + k + 1);
            end
        end
        if (rs_live && wb_we && (wb_rd == rs)) begin
            data = wb_data;
            sel  = SEL_W'(SEL_WB);
        end
        if (rs_live && mem_we && (mem_rd == rs)) begin
            data = mem_data;
            sel  = SEL_W'(SEL_MEM);
        end
        if (rs_live && ex_we && (ex_rd == rs)) begin
            data = ex_data;
            sel  = SEL_W'(SEL_EX);
        end
    end

    // A not-ready EX result only matters when EX actually wins.
    assign load_use = (sel == SEL_W'(SEL_EX)) && !ex_ready;

endmodule

// File: rtl/fwd_bypass_unit.sv
// Parametrised operand-forwarding unit.
//
// Picks, for each of NUM_SRC operands, the youngest matching value from EX,
// MEM, WB or a DEPTH-entry history of retired writebacks, else RF data.
//
// Ports:
//   clk_i, rst_i (async, active low), stall_i, cnt_clr_i
//   src_rs_i / src_rf_data_i     packed per operand, operand 0 in the LSBs
//   ex_*, mem_*, wb_*            producer write information
//   src_data_o / src_sel_o       forwarded data and source code per operand
//   hazard_o                     load-use stall request
//   fwd_cnt_o                    saturating count of forwarded operands
module fwd_bypass_unit
    import fwd_bypass_unit_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        stall_i,
    input  logic                        cnt_clr_i,
    input  logic [NUM_SRC*REG_AW-1:0]   src_rs_i,
    input  logic [NUM_SRC*DATA_W-1:0]   src_rf_data_i,
    input  logic                        ex_we_i,
    input  logic [REG_AW-1:0]           ex_rd_i,
    input  logic [DATA_W-1:0]           ex_data_i,
    input  logic                        ex_ready_i,
    input  logic                        mem_we_i,
    input  logic [REG_AW-1:0]           mem_rd_i,
    input  logic [DATA_W-1:0]           mem_data_i,
    input  logic                        wb_we_i,
    input  logic [REG_AW-1:0]           wb_rd_i,
    input  logic [DATA_W-1:0]           wb_data_i,
    output logic [NUM_SRC*DATA_W-1:0]   src_data_o,
    output logic [NUM_SRC*($clog2(DEPTH+4))-1:0] src_sel_o,
    output logic                        hazard_o,
    output logic [CNT_W-1:0]            fwd_cnt_o
);

    localparam int SEL_W = $clog2(DEPTH + 4);
    localparam int NUM_W = $clog2(NUM_SRC + 1);

    logic [DEPTH-1:0]        hist_valid;
    logic [DEPTH*REG_AW-1:0] hist_rd;
    logic [DEPTH*DATA_W-1:0] hist_data;
    logic [NUM_SRC-1:0]      load_use;
    logic [NUM_W-1:0]        fwd_num;
    logic [CNT_W:0]          cnt_sum;
    logic [CNT_W-1:0]        cnt_next;

    // Retired-writeback history: index 0 is the youngest entry. Writes to
    // the zero register are recorded as invalid so they can never match.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hist_valid <= '0;
            hist_rd    <= '0;
            hist_data  <= '0;
        end else if (!stall_i) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                hist_valid[k]                <= hist_valid[k-1];
                hist_rd[k*REG_AW +: REG_AW]  <= hist_rd[(k-1)*REG_AW +: REG_AW];
                hist_data[k*DATA_W +: DATA_W] <= hist_data[(k-1)*DATA_W +: DATA_W];
            end
            hist_valid[0]         <= wb_we_i && (wb_rd_i != REG_AW'(REG_ZERO));
            hist_rd[0 +: REG_AW]  <= wb_rd_i;
            hist_data[0 +: DATA_W] <= wb_data_i;
        end
    end

    // One independent lookup per operand.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_lookup
        fwd_lookup #(
            .DATA_W (DATA_W),
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .SEL_W  (SEL_W)
        ) u_lookup (
            .rs         (src_rs_i[i*REG_AW +: REG_AW]),
            .rf_data    (src_rf_data_i[i*DATA_W +: DATA_W]),
            .ex_we      (ex_we_i),
            .ex_rd      (ex_rd_i),
            .ex_data    (ex_data_i),
            .ex_ready   (ex_ready_i),
            .mem_we     (mem_we_i),
            .mem_rd     (mem_rd_i),
            .mem_data   (mem_data_i),
            .wb_we      (wb_we_i),
            .wb_rd      (wb_rd_i),
            .wb_data    (wb_data_i),
            .hist_valid (hist_valid),
            .hist_rd    (hist_rd),
            .hist_data  (hist_data),
            .data       (src_data_o[i*DATA_W +: DATA_W]),
            .sel        (src_sel_o[i*SEL_W +: SEL_W]),
            .load_use   (load_use[i])
        );
    end

    assign hazard_o = |load_use;

    // Number of operands served by anything other than the register file,
    // and the saturating sum. The extra sum bit flags overflow because at
    // most NUM_SRC is added per cycle.
    always_comb begin
        fwd_num = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_sel_o[i*SEL_W +: SEL_W] != SEL_W'(SEL_RF)) begin
                fwd_num = fwd_num + NUM_W'(1);
            end
        end
        cnt_sum  = {1'b0, fwd_cnt_o} + (CNT_W+1)'(fwd_num);
        cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // Clear beats everything; a stalled or hazarded cycle does not count.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fwd_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            fwd_cnt_o <= '0;
        end else if (!stall_i && !hazard_o) begin
            fwd_cnt_o <= cnt_next;
        end
    end

endmodule

// File: tb/tb_fwd_bypass_unit.sv
// Self-checking bench for fwd_bypass_unit (DEPTH=2, NUM_SRC=2, CNT_W=4).
// Expected values come from a producer-list reference model.
module tb_fwd_bypass_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 2;
    localparam int D  = 2;
    localparam int CW = 4;
    localparam int SW = 3;
    localparam int CNT_MAX = 15;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             stall_i;
    logic             cnt_clr_i;
    logic [NS*AW-1:0] src_rs_i;
    logic [NS*DW-1:0] src_rf_data_i;
    logic             ex_we_i, mem_we_i, wb_we_i, ex_ready_i;
    logic [AW-1:0]    ex_rd_i, mem_rd_i, wb_rd_i;
    logic [DW-1:0]    ex_data_i, mem_data_i, wb_data_i;
    logic [NS*DW-1:0] src_data_o;
    logic [NS*SW-1:0] src_sel_o;
    logic             hazard_o;
    logic [CW-1:0]    fwd_cnt_o;

    logic [AW-1:0] rs [NS];
    logic [DW-1:0] rf [NS];

    logic          h_valid [D];
    logic [AW-1:0] h_rd    [D];
    logic [DW-1:0] h_data  [D];
    int            m_cnt;

    logic [SW-1:0] exp_sel  [NS];
    logic [DW-1:0] exp_data [NS];
    logic          exp_haz;
    int            exp_nfwd;

    int n_vec = 0;
    int n_err = 0;

    fwd_bypass_unit #(
        .DATA_W  (DW),
        .REG_AW  (AW),
        .NUM_SRC (NS),
        .DEPTH   (D),
        .CNT_W   (CW)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .cnt_clr_i     (cnt_clr_i),
        .src_rs_i      (src_rs_i),
        .src_rf_data_i (src_rf_data_i),
        .ex_we_i       (ex_we_i),
        .ex_rd_i       (ex_rd_i),
        .ex_data_i     (ex_data_i),
        .ex_ready_i    (ex_ready_i),
        .mem_we_i      (mem_we_i),
        .mem_rd_i      (mem_rd_i),
        .mem_data_i    (mem_data_i),
        .wb_we_i       (wb_we_i),
        .wb_rd_i       (wb_rd_i),
        .wb_data_i     (wb_data_i),
        .src_data_o    (src_data_o),
        .src_sel_o     (src_sel_o),
        .hazard_o      (hazard_o),
        .fwd_cnt_o     (fwd_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // One comparison: counts the vector and reports any difference.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic packInputs();
        for (int o = 0; o < NS; o++) begin
            src_rs_i[o*AW +: AW]      = rs[o];
            src_rf_data_i[o*DW +: DW] = rf[o];
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < D; k++) begin
            h_valid[k] = 1'b0;
            h_rd[k]    = '0;
            h_data[k]  = '0;
        end
        m_cnt = 0;
    endtask

    // Producers listed youngest first; the first live match wins and its
    // list position + 1 is the select code.
    task automatic computeExpected();
        logic          cw [3+D];
        logic [AW-1:0] crd[3+D];
        logic [DW-1:0] cdt[3+D];
        cw[0] = ex_we_i;  crd[0] = ex_rd_i;  cdt[0] = ex_data_i;
        cw[1] = mem_we_i; crd[1] = mem_rd_i; cdt[1] = mem_data_i;
        cw[2] = wb_we_i;  crd[2] = wb_rd_i;  cdt[2] = wb_data_i;
        for (int k = 0; k < D; k++) begin
            cw[3+k] = h_valid[k]; crd[3+k] = h_rd[k]; cdt[3+k] = h_data[k];
        end
        exp_haz  = 1'b0;
        exp_nfwd = 0;
        for (int o = 0; o < NS; o++) begin
            bit found = 0;
            exp_sel[o]  = '0;
            exp_data[o] = rf[o];
            if (rs[o] != 0) begin
                for (int i = 0; i < 3 + D; i++) begin
                    if (!found && cw[i] && crd[i] == rs[o]) begin
                        found       = 1;
                        exp_sel[o]  = SW'(i + 1);
                        exp_data[o] = cdt[i];
                    end
                end
            end
            if (exp_sel[o] == 1 && !ex_ready_i) exp_haz = 1'b1;
            if (exp_sel[o] != 0) exp_nfwd++;
        end
    endtask

    // One clock: check lookups, advance the model across the edge, check count.
    task automatic applyStimulus();
        packInputs();
        if (!rst_i) clearModel();
        computeExpected();
        #1;
        for (int o = 0; o < NS; o++) begin
            checkOutput($sformatf("sel%0d", o), 32'(src_sel_o[o*SW +: SW]), 32'(exp_sel[o]));
            if (!(exp_sel[o] == 1 && !ex_ready_i))
                checkOutput($sformatf("data%0d", o), src_data_o[o*DW +: DW], exp_data[o]);
        end
        checkOutput("hazard", 32'(hazard_o), 32'(exp_haz));
        @(posedge clk_i);
        if (rst_i) begin
            if (cnt_clr_i) m_cnt = 0;
            else if (!stall_i && !exp_haz) m_cnt = (m_cnt + exp_nfwd > CNT_MAX) ? CNT_MAX : m_cnt + exp_nfwd;
            if (!stall_i) begin
                for (int k = D - 1; k >= 1; k--) begin
                    h_valid[k] = h_valid[k-1]; h_rd[k] = h_rd[k-1]; h_data[k] = h_data[k-1];
                end
                h_valid[0] = wb_we_i && (wb_rd_i != 0);
                h_rd[0]    = wb_rd_i;
                h_data[0]  = wb_data_i;
            end
        end
        #1;
        checkOutput("cnt", 32'(fwd_cnt_o), 32'(m_cnt));
    endtask

    task automatic idleProducers();
        ex_we_i = 0; mem_we_i = 0; wb_we_i = 0; ex_ready_i = 1;
        ex_rd_i = '0; mem_rd_i = '0; wb_rd_i = '0;
        ex_data_i = '0; mem_data_i = '0; wb_data_i = '0;
        stall_i = 0; cnt_clr_i = 0;
    endtask

    initial begin
        rst_i = 0;
        idleProducers();
        rs[0] = 5; rs[1] = 0; rf[0] = 32'h11; rf[1] = 32'h22;
        clearModel();

        // Power-on reset: pass-through
        applyStimulus();
        rst_i = 1;

        // EX and MEM both write r3; EX wins
        ex_we_i = 1; ex_rd_i = 3; ex_data_i = 32'hAAAA;
        mem_we_i = 1; mem_rd_i = 3; mem_data_i = 32'hBBBB;
        rs[0] = 3; packInputs(); #1;
        checkOutput("t2_sel0", 32'(src_sel_o[SW-1:0]), 32'd1);
        checkOutput("t2_data0", src_data_o[DW-1:0], 32'hAAAA);
        applyStimulus();
        checkOutput("t2_cnt", 32'(fwd_cnt_o), 32'd1);

        // A single WB ages through the history: 3, 4, 5, then RF
        idleProducers();
        wb_we_i = 1; wb_rd_i = 7; wb_data_i = 32'h1234; rs[0] = 7; rf[0] = 32'h55;
        packInputs(); #1;
        checkOutput("t3_sel_wb", 32'(src_sel_o[SW-1:0]), 32'd3);
        applyStimulus();
        wb_we_i = 0; packInputs(); #1;
        checkOutput("t3_sel_h1", 32'(src_sel_o[SW-1:0]), 32'd4);
        checkOutput("t3_data_h1", src_data_o[DW-1:0], 32'h1234);
        applyStimulus();
        packInputs(); #1;
        checkOutput("t3_sel_h2", 32'(src_sel_o[SW-1:0]), 32'd5);
        applyStimulus();
        packInputs(); #1;
        checkOutput("t3_sel_rf", 32'(src_sel_o[SW-1:0]), 32'd0);
        checkOutput("t3_data_rf", src_data_o[DW-1:0], 32'h55);
        applyStimulus();

        // Load-use on operand 1 while stalled; WB r9 must not enter history
        ex_we_i = 1; ex_rd_i = 4; ex_ready_i = 0; ex_data_i = 32'hDEAD;
        wb_we_i = 1; wb_rd_i = 9; wb_data_i = 32'h9999;
        rs[0] = 0; rs[1] = 4; stall_i = 1;
        packInputs(); #1;
        checkOutput("t4_hazard", 32'(hazard_o), 32'd1);
        checkOutput("t4_sel1", 32'(src_sel_o[2*SW-1:SW]), 32'd1);
        applyStimulus();
        idleProducers(); rs[0] = 9; rs[1] = 0; packInputs(); #1;
        checkOutput("t4_stall_hold", 32'(src_sel_o[SW-1:0]), 32'd0);
        applyStimulus();

        // Writes to r0 are never forwarded
        ex_we_i = 1; mem_we_i = 1; wb_we_i = 1;
        ex_data_i = 32'h1; mem_data_i = 32'h2; wb_data_i = 32'h3;
        rs[0] = 0; rs[1] = 0;
        applyStimulus();
        applyStimulus();

        // Saturation: both operands forward from EX every cycle
        idleProducers(); cnt_clr_i = 1; applyStimulus(); cnt_clr_i = 0;
        ex_we_i = 1; ex_rd_i = 6; ex_data_i = 32'h66; rs[0] = 6; rs[1] = 6;
        for (int i = 0; i < 9; i++) begin
            applyStimulus();
            checkOutput("t6_sat", 32'(fwd_cnt_o), 32'((2 * (i + 1) > 15) ? 15 : 2 * (i + 1)));
        end
        cnt_clr_i = 1; applyStimulus();
        checkOutput("t6_clr", 32'(fwd_cnt_o), 32'd0);
        cnt_clr_i = 0;

        // Reset mid-run: r5 in history vanishes immediately
        idleProducers(); wb_we_i = 1; wb_rd_i = 5; wb_data_i = 32'h5555;
        applyStimulus();
        wb_we_i = 0; rs[0] = 5; rf[0] = 32'h11; packInputs(); #1;
        checkOutput("t1_pre_sel", 32'(src_sel_o[SW-1:0]), 32'd4);
        rst_i = 0; #1;
        checkOutput("t1_sel", 32'(src_sel_o[SW-1:0]), 32'd0);
        checkOutput("t1_data", src_data_o[DW-1:0], 32'h11);
        checkOutput("t1_cnt", 32'(fwd_cnt_o), 32'd0);
        applyStimulus();
        rst_i = 1;

        // Randomised traffic over a small register window
        for (int n = 0; n < 400; n++) begin
            ex_we_i  = 1'($urandom_range(1));  ex_rd_i  = AW'($urandom_range(7)); ex_data_i  = $urandom;
            mem_we_i = 1'($urandom_range(1));  mem_rd_i = AW'($urandom_range(7)); mem_data_i = $urandom;
            wb_we_i  = 1'($urandom_range(1));  wb_rd_i  = AW'($urandom_range(7)); wb_data_i  = $urandom;
            ex_ready_i = ($urandom_range(9) < 8);
            stall_i    = ($urandom_range(9) < 2);
            cnt_clr_i  = ($urandom_range(19) == 0);
            rst_i      = ($urandom_range(49) != 0);
            for (int o = 0; o < NS; o++) begin
                rs[o] = AW'($urandom_range(7));
                rf[o] = $urandom;
            end
            applyStimulus();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fwd_bypass_unit.md
Name: fwd_bypass_unit

Overview:
- Parametrised operand-forwarding unit for the pipelined CPU.
- Replaces the fixed 3-input, 2-bit-select forwarding muxes with one block that serves NUM_SRC source operands.
- For each operand it picks the youngest matching value from EX, MEM, WB or a DEPTH-entry history of retired writebacks, falling back to register-file data when nothing matches.
- Detects load-use hazards and keeps a saturating forward-event counter. Sits between decode/issue and the ALU operand muxes.

Parameters:
DATA_W, 32, operand/result width
REG_AW, 5, register address width; register 0 never forwarded
NUM_SRC, 2, number of source operands looked up per cycle
DEPTH, 2, retired-writeback history entries (covers RF write/read ordering gaps)
CNT_W, 16, forward-event counter width
SEL_W, $clog2(DEPTH+4), width of per-operand select code (derived, not overridden)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-low reset
stall_i  in  1  pipeline stall; history and counter hold
cnt_clr_i  in  1  synchronous clear of forward-event counter
src_rs_i  in  NUM_SRC*REG_AW  source register addresses, operand 0 in LSBs
src_rf_data_i  in  NUM_SRC*DATA_W  register-file read data per operand
ex_we_i  in  1  EX-stage instruction writes a register
ex_rd_i  in  REG_AW  EX destination
ex_data_i  in  DATA_W  EX result
ex_ready_i  in  1  EX result valid this cycle (0 for a load in EX)
mem_we_i / mem_rd_i / mem_data_i  in  1 / REG_AW / DATA_W  MEM-stage write info
wb_we_i / wb_rd_i / wb_data_i  in  1 / REG_AW / DATA_W  WB-stage write info
src_data_o  out  NUM_SRC*DATA_W  forwarded operand data
src_sel_o  out  NUM_SRC*SEL_W  per-operand source code
hazard_o  out  1  load-use hazard; stall request
fwd_cnt_o  out  CNT_W  saturating count of forwarded operands

Behaviour:
- Reset (rst_i low, asynchronous): all history entries invalid (valid=0, rd=0, data=0); fwd_cnt_o=0.
  - With the history empty, outputs are combinational pass-through: src_data_o=src_rf_data_i, src_sel_o=0, hazard_o=0 (assuming no live matches).
- History is a shift register: entry 1 is youngest, entry DEPTH is oldest.
  - On each rising edge with stall_i=0: entry k+1 takes entry k; entry 1 takes {wb_we_i && wb_rd_i!=0, wb_rd_i, wb_data_i}.
  - With stall_i=1 the history holds and the WB inputs are ignored.
- Match rule per operand: a producer matches when its write-enable/valid is 1, its rd equals src_rs, and src_rs != 0.
- Priority is youngest first. Select codes: EX=1, MEM=2, WB=3, history entry k = 3+k. No match gives 0 (RF).
  - src_data_o takes the winning producer's data.
  - src_sel_o is combinational, same cycle, with zero latency.
- Load-use: if the winning producer for any operand is EX and ex_ready_i=0, then hazard_o=1.
  - That operand's src_sel_o is still 1, but its src_data_o is don't-care; the bench checks only the select code.
  - Operands below EX priority are unaffected.
- Counter, on the rising edge:
  - cnt_clr_i=1: the counter goes to 0. cnt_clr_i has priority over everything else.
  - Otherwise, if stall_i=0 and hazard_o=0: add the number of operands with sel!=0 this cycle (0..NUM_SRC), saturating at 2^CNT_W-1. No wrap.
  - Otherwise: hold.
- Simultaneous events:
  - Two operands with the same register resolve independently and identically.
  - When EX and MEM share an rd, EX wins.
  - When the same rd appears in several history entries, the youngest entry wins.
- Reset asserted mid-operation clears the history immediately. Lookups in the same cycle see an empty history.

Decomposition:
- Shared package holds:
  - fwd_sel_e select-code constants: SEL_RF=0, SEL_EX=1, SEL_MEM=2, SEL_WB=3, SEL_HIST_BASE=3.
  - The history-entry struct {valid, rd, data}.
  - The REG_ZERO constant.
- One natural sub-module: fwd_lookup.
  - Combinational priority match for one operand, instantiated NUM_SRC times by a generate loop.
- History shift register, hazard OR-reduction and counter stay in the top.

Test Plan:
1. Reset with rst_i=0 mid-run, src_rs=5, rf_data=0x11 -> history cleared asynchronously; src_data=0x11, sel=0, fwd_cnt_o=0.
2. EX writes r3=0xAAAA, MEM writes r3=0xBBBB (ex_ready_i=1), src_rs0=3 -> data0=0xAAAA, sel0=1; next edge fwd_cnt_o increments by 1.
3. WB writes r7=0x1234 for one cycle, stall_i=0, DEPTH=2, src_rs0=7 held with no other producers -> sel 3, then 4, then 5, then 0 on successive cycles; data=0x1234 until sel is 0, after which data=rf_data.
4. Load in EX (ex_we_i=1, ex_rd_i=4, ex_ready_i=0), src_rs1=4 -> hazard_o=1, sel1=1, counter holds; stall_i=1 keeps the history unchanged.
5. Write to r0 from EX/MEM/WB with src_rs0=src_rs1=0 -> sel=0 and data=rf_data for both operands; no history entry becomes valid.
6. CNT_W=4, both operands forwarding every cycle -> count goes 2,4,…,14,15 and stays at 15; cnt_clr_i=1 while forwarding continues -> 0 on that edge.
